// File: rtl/tl_ul_data_responder.sv
// TileLink-UL data-port responder: single outstanding request,
// register-array memory, programmable response latency.
module tl_ul_data_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SOURCE_W = 4,
  parameter int SIZE_W = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int MEM_WORDS = 1024,
  parameter int RESP_LAT = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [2:0]            a_opcode,
  input  logic [2:0]            a_param,
  input  logic [SIZE_W-1:0]     a_size,
  input  logic [SOURCE_W-1:0]   a_source,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [DATA_W/8-1:0]   a_mask,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  a_corrupt,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [2:0]            d_opcode,
  output logic [1:0]            d_param,
  output logic [SIZE_W-1:0]     d_size,
  output logic [SOURCE_W-1:0]   d_source,
  output logic                  d_sink,
  output logic                  d_denied,
  output logic [DATA_W-1:0]     d_data,
  output logic                  d_corrupt,
  output logic [7:0]            err_count
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_LSB = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(MEM_WORDS) << OFF_LSB;
  localparam logic [3:0] LAT_M1 =
    (RESP_LAT > 0) ? 4'(RESP_LAT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;
  logic [3:0] r_cnt;

  logic [2:0]          r_d_opcode;
  logic [SIZE_W-1:0]   r_d_size;
  logic [SOURCE_W-1:0] r_d_source;
  logic                r_d_denied;
  logic [DATA_W-1:0]   r_d_data;
  logic                r_d_corrupt;
  logic [7:0]          r_err;

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic              w_accept;
  logic [ADDR_W:0]   w_diff;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_size_mask;
  logic              w_misalign;
  logic              w_multi;
  logic              w_is_put;
  logic              w_is_get;
  logic              w_data_op;
  logic              w_denied;
  logic              w_wr;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused;

  assign w_unused = ^a_param;

  assign a_ready  = (r_state == S_IDLE);
  assign w_accept = a_valid & a_ready;

  // Top bit of the widened subtraction is the borrow.
  assign w_diff     = {1'b0, a_address} - {1'b0, BASE_ADDR};
  assign w_in_range = !w_diff[ADDR_W] && (w_diff < LIMIT);
  assign w_idx      = w_diff[OFF_LSB +: IDX_W];

  assign w_size_mask = (ADDR_W'(1) << a_size) - ADDR_W'(1);
  assign w_misalign  = |(a_address & w_size_mask);
  assign w_multi     = a_size > SIZE_W'(OFF_LSB);

  always_comb begin
    w_is_put  = 1'b0;
    w_is_get  = 1'b0;
    w_data_op = 1'b0;
    unique case (a_opcode)
      3'd0, 3'd1: w_is_put = 1'b1;
      3'd4: begin
        w_is_get  = 1'b1;
        w_data_op = 1'b1;
      end
      3'd2, 3'd3: w_data_op = 1'b1;
      default: ;
    endcase
  end

  assign w_denied = !w_in_range
                  | w_misalign
                  | w_multi
                  | !(w_is_put | w_is_get)
                  | (w_is_put & a_corrupt);

  assign w_wr      = w_accept & w_is_put & !w_denied;
  assign w_rd_word = r_mem[w_idx];

  always_ff @(posedge clock) begin
    if (w_wr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (a_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= a_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (a_valid) begin
          w_next = (RESP_LAT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_RESP;
      end
      S_RESP: begin
        if (d_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_d_opcode  <= 3'd0;
      r_d_size    <= '0;
      r_d_source  <= '0;
      r_d_denied  <= 1'b0;
      r_d_data    <= '0;
      r_d_corrupt <= 1'b0;
      r_err       <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt       <= LAT_M1;
        r_d_opcode  <= {2'b00, w_data_op};
        r_d_size    <= a_size;
        r_d_source  <= a_source;
        r_d_denied  <= w_denied;
        r_d_data    <= (w_is_get && !w_denied) ? w_rd_word : '0;
        r_d_corrupt <= w_data_op & w_denied;
        if (w_denied && r_err != 8'hFF) begin
          r_err <= r_err + 8'd1;
        end
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign d_valid   = (r_state == S_RESP);
  assign d_opcode  = r_d_opcode;
  assign d_param   = 2'b00;
  assign d_size    = r_d_size;
  assign d_source  = r_d_source;
  assign d_sink    = 1'b0;
  assign d_denied  = r_d_denied;
  assign d_data    = r_d_data;
  assign d_corrupt = r_d_corrupt;
  assign err_count = r_err;

endmodule

// File: tb/tb_tl_ul_data_responder.sv
// Scoreboard bench for tl_ul_data_responder: random and directed
// A-channel traffic against a byte-level reference memory.
module tb_tl_ul_data_responder;

  localparam int LAT = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [2:0]  a_size = '0;
  logic [3:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        a_corrupt = 1'b0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;
  logic [7:0]  err_count;

  tl_ul_data_responder #(
    .ADDR_W(32), .DATA_W(32), .SOURCE_W(4), .SIZE_W(3),
    .BASE_ADDR(BASE), .MEM_WORDS(1024), .RESP_LAT(LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        den;
    logic [31:0] data;
    logic [3:0]  known;
    logic        cor;
  } exp_t;

  exp_t q[$];
  byte unsigned mdl[int unsigned];
  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [31:0] last_data = '0;
  logic        last_den = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [2:0] size,
                       input logic [3:0] src, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data,
                       input logic cor, output exp_t e);
    longint off;
    int unsigned w;
    bit in_r, ali, multi, legal, put;
    off   = longint'(addr) - longint'(BASE);
    in_r  = (off >= 0) && (off < 1024 * 4);
    ali   = (int'(addr) % (1 << size)) == 0;
    multi = (1 << size) > 4;
    legal = (op == 0) || (op == 1) || (op == 4);
    put   = (op == 0) || (op == 1);
    e.op    = (op == 2 || op == 3 || op == 4) ? 3'd1 : 3'd0;
    e.size  = size;
    e.src   = src;
    e.den   = !in_r || !ali || multi || !legal || (put && cor);
    e.cor   = e.op[0] && e.den;
    e.data  = '0;
    e.known = 4'hF;
    if (!e.den) begin
      w = int'(off) & ~3;
      for (int b = 0; b < 4; b++) begin
        if (put && mask[b]) mdl[w + b] = data[8*b +: 8];
        if (op == 4) begin
          if (mdl.exists(w + b)) e.data[8*b +: 8] = mdl[w + b];
          else e.known[b] = 1'b0;
        end
      end
    end
    if (e.den && exp_err < 255) exp_err++;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] size,
                      input logic [3:0] src, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data,
                      input logic cor);
    exp_t e;
    int n;
    @(posedge clock);
    #1;
    a_opcode  = op;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_corrupt = cor;
    a_param   = 3'($urandom);
    a_valid   = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (a_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 1, 0);
        a_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    model(op, size, src, addr, mask, data, cor, e);
    q.push_back(e);
    @(posedge clock);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) return;
      @(negedge clock);
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0: d_ready = 1'($urandom_range(0, 1));
        1: d_ready = 1'b0;
        default: d_ready = 1'b1;
      endcase
    end
  end

  initial begin
    exp_t e;
    logic [31:0] km;
    logic [43:0] saved;
    logic [43:0] cur;
    bit stall;
    stall = 0;
    saved = '0;
    forever begin
      @(negedge clock);
      cur = {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
      if (!reset_n) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("d_hold_valid", d_valid, 1);
          chk("d_stable", cur, saved);
        end
        if (d_valid && d_ready) begin
          stall = 0;
          if (q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
          end else begin
            e = q.pop_front();
            for (int b = 0; b < 4; b++) km[8*b +: 8] = {8{e.known[b]}};
            chk("d_opcode", d_opcode, e.op);
            chk("d_source", d_source, e.src);
            chk("d_size", d_size, e.size);
            chk("d_denied", d_denied, e.den);
            chk("d_corrupt", d_corrupt, e.cor);
            chk("d_data", d_data & km, e.data & km);
            chk("d_param_sink", {d_param, d_sink}, 0);
            chk("err_count", err_count, exp_err);
            last_data = d_data;
            last_den  = d_denied;
          end
        end else if (d_valid) begin
          stall = 1;
          saved = cur;
        end else begin
          stall = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit bad;
    int n;
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [31:0] ad;

    #2 reset_n = 1'b0;
    #1;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_fields", {d_opcode, d_size, d_source, d_denied,
                         d_corrupt, d_data}, 0);
    chk("rst_err", err_count, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    send(3'd0, 3'd2, 4'd3, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    send(3'd4, 3'd2, 4'd5, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    wait_idle();
    chk("plan_read_back", last_data, 32'hDEAD_BEEF);

    send(3'd1, 3'd2, 4'd2, BASE + 32'h10, 4'b0101, 32'h1122_3344, 1'b0);
    send(3'd4, 3'd2, 4'd5, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    wait_idle();
    chk("plan_partial", last_data, 32'hDE22_BE44);

    send(3'd4, 3'd2, 4'd1, 32'h7FFF_FFFC, 4'hF, 32'h0, 1'b0);
    wait_idle();
    chk("plan_below_den", last_den, 1);
    send(3'd4, 3'd2, 4'd1, 32'h8000_1000, 4'hF, 32'h0, 1'b0);
    wait_idle();
    chk("plan_above_den", last_den, 1);
    chk("plan_err2", err_count, 2);

    send(3'd4, 3'd2, 4'd6, BASE + 32'h2, 4'hF, 32'h0, 1'b0);
    wait_idle();
    chk("plan_misalign_den", last_den, 1);
    send(3'd4, 3'd3, 4'd6, BASE, 4'hF, 32'h0, 1'b0);
    wait_idle();
    chk("plan_multibeat_den", last_den, 1);
    send(3'd0, 3'd2, 4'd6, BASE + 32'h12, 4'hF, 32'hFFFF_FFFF, 1'b0);
    send(3'd4, 3'd2, 4'd6, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    wait_idle();
    chk("plan_no_change", last_data, 32'hDE22_BE44);

    rdy_mode = 1;
    send(3'd4, 3'd2, 4'd7, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    n = 0;
    bad = 0;
    while (!d_valid && n < 20) begin
      @(negedge clock);
      if (!d_valid && a_ready) bad = 1;
      n++;
    end
    chk("lat_d_valid_rise", cyc - acc_cyc, LAT + 1);
    repeat (5) begin
      @(negedge clock);
      if (a_ready || !d_valid) bad = 1;
    end
    chk("lat_a_ready_low", bad, 0);
    rdy_mode = 2;
    @(negedge clock);
    chk("hs_a_ready_busy", a_ready, 0);
    @(negedge clock);
    chk("hs_a_ready_after", a_ready, 1);
    chk("hs_d_valid_after", d_valid, 0);

    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      n  = $urandom_range(0, 9);
      op = (n < 3) ? 3'd4 : (n < 5) ? 3'd0 : (n < 7) ? 3'd1
         : 3'($urandom_range(0, 7));
      sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2))
         : 3'($urandom_range(0, 7));
      ad = ($urandom_range(0, 15) == 0) ? 32'($urandom)
         : BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      send(op, sz, 4'($urandom), ad, 4'($urandom), 32'($urandom),
           1'($urandom_range(0, 7) == 0));
    end
    wait_idle();

    rdy_mode = 2;
    for (int i = 0; i < 260; i++) begin
      send(3'd4, 3'd2, 4'd9, 32'h1000_0000, 4'hF, 32'h0, 1'b0);
    end
    wait_idle();
    chk("err_saturate", err_count, 255);

    send(3'd0, 3'd2, 4'd1, BASE + 32'h20, 4'hF, 32'hCAFE_F00D, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_d_valid", d_valid, 0);
    chk("midrst_a_ready", a_ready, 1);
    chk("midrst_err", err_count, 0);
    q.delete();
    exp_err = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (d_valid) seen = 1;
    end
    chk("midrst_no_resp", seen, 0);
    send(3'd4, 3'd2, 4'd4, BASE + 32'h20, 4'hF, 32'h0, 1'b0);
    wait_idle();
    chk("midrst_write_kept", last_data, 32'hCAFE_F00D);

    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
